// File: rtl/clear_global_lvl_states_pkg.sv
// Shared level-state layout and walker state encodings.
// Used by the backtrack-level search and the clear walker.
package clear_global_lvl_states_pkg;

  localparam int LVL_W       = 16;
  localparam int BIN_ID_W    = 10;
  localparam int LVL_STATE_W = 11;
  localparam int LS_ADDR_W   = 9;

  // {dcd_bin, has_bkt}
  localparam int HAS_BKT_BIT = 0;
  localparam int DCD_BIN_LSB = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DRAIN,
    ST_DONE
  } clr_state_e;

endpackage

// File: rtl/clear_global_lvl_states_lvl_rd_pipe.sv
// Two-stage valid/address delay line for level-state BRAM walkers.
// Stage 1 is the registered read address; stage 2 lines up with read data.
module lvl_rd_pipe #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_vld,
  input  logic [AW-1:0] issue_addr,
  output logic [AW-1:0] rd_addr,
  output logic          vld,
  output logic [AW-1:0] addr
);

  logic s1_vld;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      rd_addr <= '0;
      vld     <= 1'b0;
      addr    <= '0;
    end else begin
      s1_vld <= issue_vld;
      if (issue_vld) rd_addr <= issue_addr;
      vld  <= s1_vld;
      addr <= rd_addr;
    end
  end

endmodule

// File: rtl/clear_global_lvl_states.sv
// Global-backtrack cleanup: zeroes level states cur..bkt+1, counts has_bkt.
// Optional trace: define CLEAR_LVL_STATES_DEBUG_EN.
module clear_global_lvl_states
  import clear_global_lvl_states_pkg::*;
#(
  parameter int WIDTH_LVL             = LVL_W,
  parameter int WIDTH_BIN_ID          = BIN_ID_W,
  parameter int WIDTH_LVL_STATES      = LVL_STATE_W,
  parameter int ADDR_WIDTH_LVL_STATES = LS_ADDR_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_clear,
  output logic                             apply_clear_o,
  output logic                             done_clear,
  input  logic [WIDTH_LVL-1:0]             cur_lvl_i,
  input  logic [WIDTH_LVL-1:0]             bkt_lvl_i,
  input  logic [WIDTH_BIN_ID-1:0]          bkt_bin_i,
  output logic [WIDTH_LVL-1:0]             cur_lvl_o,
  output logic [WIDTH_BIN_ID-1:0]          cur_bin_o,
  output logic [WIDTH_LVL-1:0]             n_marked_o,
  output logic [ADDR_WIDTH_LVL_STATES-1:0] ram_raddr_ls_o,
  input  logic [WIDTH_LVL_STATES-1:0]      ram_rdata_ls_i,
  output logic                             ram_we_ls_o,
  output logic [ADDR_WIDTH_LVL_STATES-1:0] ram_waddr_ls_o,
  output logic [WIDTH_LVL_STATES-1:0]      ram_wdata_ls_o
);

  localparam int AW = ADDR_WIDTH_LVL_STATES;

  clr_state_e state;

  logic [WIDTH_LVL-1:0]    cur_q;
  logic [WIDTH_LVL-1:0]    bkt_q;
  logic [WIDTH_BIN_ID-1:0] bin_q;
  logic [WIDTH_LVL-1:0]    ptr;
  logic                    drain_cnt;
  logic                    done_d;

  logic          issue_vld;
  logic [AW-1:0] issue_addr;
  logic          pipe_vld;
  logic [AW-1:0] pipe_addr;
  logic          has_bkt;
  logic          unused_dcd_bin;

  assign has_bkt = ram_rdata_ls_i[HAS_BKT_BIT];
  assign unused_dcd_bin =
    ^ram_rdata_ls_i[WIDTH_LVL_STATES-1:DCD_BIN_LSB];

  // First address goes out on the accepting edge itself.
  always_comb begin
    issue_vld  = 1'b0;
    issue_addr = '0;
    unique case (1'b1)
      (state == ST_IDLE) && start_clear &&
      (cur_lvl_i > bkt_lvl_i): begin
        issue_vld  = 1'b1;
        issue_addr = cur_lvl_i[AW-1:0];
      end
      (state == ST_CLEAR): begin
        issue_vld  = 1'b1;
        issue_addr = ptr[AW-1:0];
      end
      default: ;
    endcase
  end

  lvl_rd_pipe #(.AW(AW)) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .issue_vld  (issue_vld),
    .issue_addr (issue_addr),
    .rd_addr    (ram_raddr_ls_o),
    .vld        (pipe_vld),
    .addr       (pipe_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ST_IDLE;
      cur_q          <= '0;
      bkt_q          <= '0;
      bin_q          <= '0;
      ptr            <= '0;
      drain_cnt      <= 1'b0;
      done_d         <= 1'b0;
      done_clear     <= 1'b0;
      apply_clear_o  <= 1'b0;
      cur_lvl_o      <= '0;
      cur_bin_o      <= '0;
      n_marked_o     <= '0;
      ram_we_ls_o    <= 1'b0;
      ram_waddr_ls_o <= '0;
      ram_wdata_ls_o <= '0;
    end else begin
      ram_we_ls_o    <= pipe_vld;
      ram_waddr_ls_o <= pipe_addr;
      ram_wdata_ls_o <= '0;
      if (pipe_vld && has_bkt && !(&n_marked_o))
        n_marked_o <= n_marked_o + WIDTH_LVL'(1);
      done_d     <= (state == ST_DONE);
      done_clear <= done_d;
      case (state)
        ST_IDLE: begin
          if (start_clear) begin
            cur_q         <= cur_lvl_i;
            bkt_q         <= bkt_lvl_i;
            bin_q         <= bkt_bin_i;
            n_marked_o    <= '0;
            apply_clear_o <= 1'b1;
            drain_cnt     <= 1'b0;
            ptr           <= cur_lvl_i - WIDTH_LVL'(1);
            if (cur_lvl_i <= bkt_lvl_i)
              state <= ST_DONE;
            else if (cur_lvl_i == bkt_lvl_i + WIDTH_LVL'(1))
              state <= ST_DRAIN;
            else
              state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          ptr <= ptr - WIDTH_LVL'(1);
          if (ptr == bkt_q + WIDTH_LVL'(1)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= ST_DONE;
        end
        ST_DONE: begin
          state         <= ST_IDLE;
          apply_clear_o <= 1'b0;
          cur_lvl_o     <= (cur_q > bkt_q) ? bkt_q : cur_q;
          cur_bin_o     <= bin_q;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CLEAR_LVL_STATES_DEBUG_EN
  always @(posedge clk) begin
    if (apply_clear_o)
      $display("clr st=%s ra=%0d rd=%h wa=%0d nm=%0d",
               state.name(), ram_raddr_ls_o, ram_rdata_ls_i,
               ram_waddr_ls_o, n_marked_o);
  end
`endif

endmodule

// File: tb/tb_clear_global_lvl_states.sv
// Directed bench for clear_global_lvl_states with a behavioural BRAM.
// Edge offsets are counted from the start-sampling edge E0.
module tb_clear_global_lvl_states;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_clear = 1'b0;
  logic        apply_clear_o;
  logic        done_clear;
  logic [15:0] cur_lvl_i = '0;
  logic [15:0] bkt_lvl_i = '0;
  logic [9:0]  bkt_bin_i = '0;
  logic [15:0] cur_lvl_o;
  logic [9:0]  cur_bin_o;
  logic [15:0] n_marked_o;
  logic [8:0]  ram_raddr_ls_o;
  logic [10:0] ram_rdata_ls_i = '0;
  logic        ram_we_ls_o;
  logic [8:0]  ram_waddr_ls_o;
  logic [10:0] ram_wdata_ls_o;

  always #5 clk = ~clk;

  clear_global_lvl_states dut (
    .clk            (clk),
    .rst            (rst),
    .start_clear    (start_clear),
    .apply_clear_o  (apply_clear_o),
    .done_clear     (done_clear),
    .cur_lvl_i      (cur_lvl_i),
    .bkt_lvl_i      (bkt_lvl_i),
    .bkt_bin_i      (bkt_bin_i),
    .cur_lvl_o      (cur_lvl_o),
    .cur_bin_o      (cur_bin_o),
    .n_marked_o     (n_marked_o),
    .ram_raddr_ls_o (ram_raddr_ls_o),
    .ram_rdata_ls_i (ram_rdata_ls_i),
    .ram_we_ls_o    (ram_we_ls_o),
    .ram_waddr_ls_o (ram_waddr_ls_o),
    .ram_wdata_ls_o (ram_wdata_ls_o)
  );

  logic [10:0] mem [512];

  always @(posedge clk) begin
    ram_rdata_ls_i <= mem[ram_raddr_ls_o];
    if (ram_we_ls_o) mem[ram_waddr_ls_o] = ram_wdata_ls_o;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         e0 = 1000000;
  logic [8:0] wa [$];
  int         wt [$];
  int         nd, dt, bad_wdata, wr0, rd0;
  logic       ap [64];
  int         npass = 0;
  int         ntot = 0;

  always @(negedge clk) begin
    if (ram_we_ls_o) begin
      wa.push_back(ram_waddr_ls_o);
      wt.push_back(cyc - e0);
      if (ram_wdata_ls_o != 11'd0) bad_wdata++;
      if (ram_waddr_ls_o == 9'd0) wr0++;
    end
    if (done_clear) begin
      nd++;
      dt = cyc - e0;
    end
    if (apply_clear_o && ram_raddr_ls_o == 9'd0) rd0++;
    if (cyc - e0 >= 0 && cyc - e0 < 64) ap[cyc - e0] = apply_clear_o;
  end

  task automatic start_walk(input logic [15:0] c, input logic [15:0] b,
                            input logic [9:0] bn);
    @(posedge clk);
    #1;
    wa.delete();
    wt.delete();
    nd = 0;
    dt = -1;
    bad_wdata = 0;
    wr0 = 0;
    rd0 = 0;
    for (int i = 0; i < 64; i++) ap[i] = 1'bx;
    cur_lvl_i = c;
    bkt_lvl_i = b;
    bkt_bin_i = bn;
    start_clear = 1'b1;
    e0 = cyc + 1;
    @(posedge clk);
    #1 start_clear = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (nd > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ntot++;
    if ({apply_clear_o, done_clear, ram_we_ls_o} !== 3'b000)
      $display("FAIL reset_ctl got %b want 000",
               {apply_clear_o, done_clear, ram_we_ls_o});
    else npass++;
    ntot++;
    if ({cur_lvl_o, cur_bin_o, n_marked_o} !== 42'd0)
      $display("FAIL reset_res got %h want 0",
               {cur_lvl_o, cur_bin_o, n_marked_o});
    else npass++;
    ntot++;
    if ({ram_raddr_ls_o, ram_waddr_ls_o, ram_wdata_ls_o} !== 29'd0)
      $display("FAIL reset_ram got %h want 0",
               {ram_raddr_ls_o, ram_waddr_ls_o, ram_wdata_ls_o});
    else npass++;
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic;
    bit ok;
    mem[2] = 11'h001;
    mem[3] = 11'h0a6;
    mem[4] = 11'h013;
    mem[5] = 11'h7ff;
    start_walk(16'd5, 16'd2, 10'h0c3);
    wait_done(40, ok);
    ntot++;
    if (!ok || dt !== 6) $display("FAIL basic_done got %0d want 6", dt);
    else npass++;
    ntot++;
    if (wa.size() !== 3)
      $display("FAIL basic_nwr got %0d want 3", wa.size());
    else npass++;
    for (int i = 0; i < 3; i++) begin
      ntot++;
      if (i >= wa.size() || wa[i] !== 9'(5 - i) || wt[i] !== 2 + i)
        $display("FAIL basic_wr%0d got a=%0d t=%0d want a=%0d t=%0d", i,
                 (i < wa.size()) ? int'(wa[i]) : -1,
                 (i < wt.size()) ? wt[i] : -1, 5 - i, 2 + i);
      else npass++;
    end
    ntot++;
    if (n_marked_o !== 16'd2)
      $display("FAIL basic_nmark got %0d want 2", n_marked_o);
    else npass++;
    ntot++;
    if (cur_lvl_o !== 16'd2 || cur_bin_o !== 10'h0c3)
      $display("FAIL basic_res got %0d/%h want 2/0c3", cur_lvl_o, cur_bin_o);
    else npass++;
    ntot++;
    if (mem[5] !== 11'h0 || mem[4] !== 11'h0 || mem[3] !== 11'h0 ||
        mem[2] !== 11'h001 || bad_wdata !== 0)
      $display("FAIL basic_mem got %h %h %h %h want 0 0 0 001",
               mem[5], mem[4], mem[3], mem[2]);
    else npass++;
  endtask

  task automatic test_no_levels;
    bit ok;
    start_walk(16'd3, 16'd3, 10'h2f1);
    wait_done(20, ok);
    ntot++;
    if (!ok || dt !== 2) $display("FAIL n0_done got %0d want 2", dt);
    else npass++;
    ntot++;
    if (wa.size() !== 0) $display("FAIL n0_nwr got %0d want 0", wa.size());
    else npass++;
    ntot++;
    if (cur_lvl_o !== 16'd3 || cur_bin_o !== 10'h2f1 || n_marked_o !== 16'd0)
      $display("FAIL n0_res got %0d/%h/%0d want 3/2f1/0",
               cur_lvl_o, cur_bin_o, n_marked_o);
    else npass++;
  endtask

  task automatic test_level_one;
    bit ok;
    mem[0] = 11'h555;
    mem[1] = 11'h001;
    start_walk(16'd1, 16'd0, 10'h007);
    wait_done(20, ok);
    ntot++;
    if (!ok || dt !== 4) $display("FAIL l1_done got %0d want 4", dt);
    else npass++;
    ntot++;
    if (wa.size() !== 1 || wa[0] !== 9'd1 || wt[0] !== 2)
      $display("FAIL l1_wr got n=%0d want one write to 1 at 2", wa.size());
    else npass++;
    ntot++;
    if (wr0 !== 0 || rd0 !== 0 || mem[0] !== 11'h555)
      $display("FAIL l1_addr0 got w=%0d r=%0d m=%h want 0 0 555",
               wr0, rd0, mem[0]);
    else npass++;
    ntot++;
    if (n_marked_o !== 16'd1 || cur_lvl_o !== 16'd0 || cur_bin_o !== 10'h007)
      $display("FAIL l1_res got %0d/%0d/%h want 1/0/007",
               n_marked_o, cur_lvl_o, cur_bin_o);
    else npass++;
  endtask

  task automatic test_restart_ignored;
    bit ok;
    mem[2] = 11'h001;
    mem[3] = 11'h000;
    mem[4] = 11'h003;
    mem[5] = 11'h002;
    mem[6] = 11'h7ff;
    start_walk(16'd6, 16'd1, 10'h155);
    @(posedge clk);
    @(posedge clk);
    #1;
    cur_lvl_i = 16'd9;
    bkt_lvl_i = 16'd0;
    bkt_bin_i = 10'h2aa;
    start_clear = 1'b1;
    @(posedge clk);
    #1 start_clear = 1'b0;
    wait_done(40, ok);
    ntot++;
    if (!ok || dt !== 8) $display("FAIL rs_done got %0d want 8", dt);
    else npass++;
    for (int i = 0; i < 5; i++) begin
      ntot++;
      if (i >= wa.size() || wa[i] !== 9'(6 - i) || wt[i] !== 2 + i)
        $display("FAIL rs_wr%0d got a=%0d want a=%0d", i,
                 (i < wa.size()) ? int'(wa[i]) : -1, 6 - i);
      else npass++;
    end
    ntot++;
    if (n_marked_o !== 16'd3 || cur_lvl_o !== 16'd1 || cur_bin_o !== 10'h155)
      $display("FAIL rs_res got %0d/%0d/%h want 3/1/155",
               n_marked_o, cur_lvl_o, cur_bin_o);
    else npass++;
    repeat (20) @(negedge clk);
    ntot++;
    if (nd !== 1 || wa.size() !== 5)
      $display("FAIL rs_extra got done=%0d wr=%0d want 1/5", nd, wa.size());
    else npass++;
  endtask

  task automatic test_midwalk_reset;
    start_walk(16'd8, 16'd0, 10'h0ab);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    ntot++;
    if ({apply_clear_o, done_clear, ram_we_ls_o} !== 3'b000)
      $display("FAIL mr_ctl got %b want 000",
               {apply_clear_o, done_clear, ram_we_ls_o});
    else npass++;
    ntot++;
    if ({cur_lvl_o, cur_bin_o, n_marked_o, ram_raddr_ls_o,
         ram_waddr_ls_o} !== 60'd0)
      $display("FAIL mr_out got %h want 0",
               {cur_lvl_o, cur_bin_o, n_marked_o, ram_raddr_ls_o,
                ram_waddr_ls_o});
    else npass++;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (15) @(negedge clk);
    ntot++;
    if (wa.size() !== 2 || nd !== 0 || apply_clear_o !== 1'b0)
      $display("FAIL mr_after got wr=%0d done=%0d ap=%b want 2/0/0",
               wa.size(), nd, apply_clear_o);
    else npass++;
  endtask

  task automatic test_all_marked;
    bit ok;
    for (int i = 1; i <= 9; i++) mem[i] = 11'(1 + 2 * i);
    start_walk(16'd9, 16'd0, 10'h3c0);
    wait_done(40, ok);
    ntot++;
    if (!ok || dt !== 12) $display("FAIL am_done got %0d want 12", dt);
    else npass++;
    ntot++;
    if (n_marked_o !== 16'd9 || cur_lvl_o !== 16'd0 || cur_bin_o !== 10'h3c0)
      $display("FAIL am_res got %0d/%0d/%h want 9/0/3c0",
               n_marked_o, cur_lvl_o, cur_bin_o);
    else npass++;
    ntot++;
    if (wa.size() !== 9 || wt[0] !== 2 || wt[8] !== 10 || wa[8] !== 9'd1)
      $display("FAIL am_wr got n=%0d want 9 writes at 2..10", wa.size());
    else npass++;
    ntot++;
    if (ap[0] !== 1'b1 || ap[10] !== 1'b1 || ap[11] !== 1'b0)
      $display("FAIL am_apply got %b%b%b want 110", ap[0], ap[10], ap[11]);
    else npass++;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 11'h0;
    test_reset;
    test_basic;
    test_no_levels;
    test_level_one;
    test_restart_ignored;
    test_midwalk_reset;
    test_all_marked;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
